// File: rtl/rrd_decode_pipe.sv
// Register-read decode stage: per-channel opcode decode, immediate conditioning,
// and one pipeline register per channel with backpressure, branch kill/resolve
// tracking and flush.
module rrd_decode_pipe #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned UOPC_W = 7,
    parameter int unsigned BRM_W  = 20,
    parameter int unsigned IMM_W  = 20,
    parameter int unsigned PL_W   = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        io_iss_valid,
    output logic                     io_iss_ready,
    input  logic [NUM_CH*UOPC_W-1:0] io_iss_uopc,
    input  logic [NUM_CH*5-1:0]      io_iss_mem_cmd,
    input  logic [NUM_CH*IMM_W-1:0]  io_iss_imm_packed,
    input  logic [NUM_CH*BRM_W-1:0]  io_iss_br_mask,
    input  logic [NUM_CH*PL_W-1:0]   io_iss_payload,
    input  logic [BRM_W-1:0]         io_brupdate_resolve_mask,
    input  logic [BRM_W-1:0]         io_brupdate_mispredict_mask,
    input  logic                     io_flush,
    output logic [NUM_CH-1:0]        io_rrd_valid,
    input  logic                     io_rrd_ready,
    output logic [NUM_CH*UOPC_W-1:0] io_rrd_uopc,
    output logic [NUM_CH*4-1:0]      io_rrd_br_type,
    output logic [NUM_CH*2-1:0]      io_rrd_op1_sel,
    output logic [NUM_CH*3-1:0]      io_rrd_op2_sel,
    output logic [NUM_CH*3-1:0]      io_rrd_imm_sel,
    output logic [NUM_CH*4-1:0]      io_rrd_op_fcn,
    output logic [NUM_CH-1:0]        io_rrd_fcn_dw,
    output logic [NUM_CH*IMM_W-1:0]  io_rrd_imm_packed,
    output logic [NUM_CH*BRM_W-1:0]  io_rrd_br_mask,
    output logic [NUM_CH*PL_W-1:0]   io_rrd_payload
);
    localparam int unsigned CMD_W = 5;
    localparam int unsigned BRT_W = 4;
    localparam int unsigned FCN_W = 4;

    // Pipeline register contents
    logic [NUM_CH-1:0]        valid_q,   valid_d;
    logic [NUM_CH*UOPC_W-1:0] uopc_q,    uopc_d;
    logic [NUM_CH*BRT_W-1:0]  br_type_q, br_type_d;
    logic [NUM_CH*2-1:0]      op1_q,     op1_d;
    logic [NUM_CH*3-1:0]      op2_q,     op2_d;
    logic [NUM_CH*3-1:0]      imm_sel_q, imm_sel_d;
    logic [NUM_CH*FCN_W-1:0]  op_fcn_q,  op_fcn_d;
    logic [NUM_CH-1:0]        fcn_dw_q,  fcn_dw_d;
    logic [NUM_CH*IMM_W-1:0]  imm_q,     imm_d;
    logic [NUM_CH*BRM_W-1:0]  brm_q,     brm_d;
    logic [NUM_CH*PL_W-1:0]   pl_q,      pl_d;

    logic ld;

    // Branch-type / ALU-function lookup for the listed branch opcodes
    function automatic logic [BRT_W+FCN_W-1:0] br_decode(input logic [UOPC_W-1:0] u);
        logic [BRT_W+FCN_W-1:0] r;
        r = '0;
        case (u)
            UOPC_W'('h18): r = {BRT_W'(2), FCN_W'('hE)};
            UOPC_W'('h19): r = {BRT_W'(1), FCN_W'('hA)};
            UOPC_W'('h1A): r = {BRT_W'(3), FCN_W'('hC)};
            UOPC_W'('h1B): r = {BRT_W'(4), FCN_W'('hE)};
            UOPC_W'('h1C): r = {BRT_W'(5), FCN_W'('hC)};
            UOPC_W'('h1D): r = {BRT_W'(6), FCN_W'('hE)};
            default:       r = '0;
        endcase
        return r;
    endfunction

    // 32-bit word ops clear the double-word flag
    function automatic logic fcn_dw_of(input logic [UOPC_W-1:0] u);
        return !((u >= UOPC_W'('h2B) && u <= UOPC_W'('h33)) ||
                 (u >= UOPC_W'('h38) && u <= UOPC_W'('h40)));
    endfunction

    // Immediate is meaningless for these ops and is zeroed
    function automatic logic imm_kill(input logic [UOPC_W-1:0] u, input logic [CMD_W-1:0] cmd);
        return (u == UOPC_W'('h43)) || ((u == UOPC_W'('h01)) && (cmd == CMD_W'('h6)));
    endfunction

    // Stage accepts whenever it is empty or draining this cycle
    assign io_iss_ready = ~(|valid_q) | io_rrd_ready;
    assign ld           = io_iss_ready;

    // Next-state: decode on load, otherwise hold; branch update and flush applied on top
    always_comb begin
        valid_d   = valid_q;
        uopc_d    = uopc_q;
        br_type_d = br_type_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        imm_sel_d = imm_sel_q;
        op_fcn_d  = op_fcn_q;
        fcn_dw_d  = fcn_dw_q;
        imm_d     = imm_q;
        brm_d     = brm_q;
        pl_d      = pl_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ld) begin
                uopc_d[i*UOPC_W +: UOPC_W] = io_iss_uopc[i*UOPC_W +: UOPC_W];
                {br_type_d[i*BRT_W +: BRT_W], op_fcn_d[i*FCN_W +: FCN_W]} =
                    br_decode(io_iss_uopc[i*UOPC_W +: UOPC_W]);
                op1_d[i*2 +: 2]     = '0;
                op2_d[i*3 +: 3]     = '0;
                imm_sel_d[i*3 +: 3] = '0;
                fcn_dw_d[i]         = fcn_dw_of(io_iss_uopc[i*UOPC_W +: UOPC_W]);
                imm_d[i*IMM_W +: IMM_W] =
                    imm_kill(io_iss_uopc[i*UOPC_W +: UOPC_W], io_iss_mem_cmd[i*CMD_W +: CMD_W])
                    ? '0 : io_iss_imm_packed[i*IMM_W +: IMM_W];
                pl_d[i*PL_W +: PL_W] = io_iss_payload[i*PL_W +: PL_W];
                brm_d[i*BRM_W +: BRM_W] = io_iss_br_mask[i*BRM_W +: BRM_W] & ~io_brupdate_resolve_mask;
                valid_d[i] = io_iss_valid[i] &
                             ~(|(io_iss_br_mask[i*BRM_W +: BRM_W] & io_brupdate_mispredict_mask));
            end else begin
                brm_d[i*BRM_W +: BRM_W] = brm_q[i*BRM_W +: BRM_W] & ~io_brupdate_resolve_mask;
                valid_d[i] = valid_q[i] &
                             ~(|(brm_q[i*BRM_W +: BRM_W] & io_brupdate_mispredict_mask));
            end
            if (io_flush) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    // Pipeline register with asynchronous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q   <= '0;
            uopc_q    <= '0;
            br_type_q <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            imm_sel_q <= '0;
            op_fcn_q  <= '0;
            fcn_dw_q  <= '0;
            imm_q     <= '0;
            brm_q     <= '0;
            pl_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            uopc_q    <= uopc_d;
            br_type_q <= br_type_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            imm_sel_q <= imm_sel_d;
            op_fcn_q  <= op_fcn_d;
            fcn_dw_q  <= fcn_dw_d;
            imm_q     <= imm_d;
            brm_q     <= brm_d;
            pl_q      <= pl_d;
        end
    end

    assign io_rrd_valid      = valid_q;
    assign io_rrd_uopc       = uopc_q;
    assign io_rrd_br_type    = br_type_q;
    assign io_rrd_op1_sel    = op1_q;
    assign io_rrd_op2_sel    = op2_q;
    assign io_rrd_imm_sel    = imm_sel_q;
    assign io_rrd_op_fcn     = op_fcn_q;
    assign io_rrd_fcn_dw     = fcn_dw_q;
    assign io_rrd_imm_packed = imm_q;
    assign io_rrd_br_mask    = brm_q;
    assign io_rrd_payload    = pl_q;

endmodule

// File: tb/tb_rrd_decode_pipe.sv
// Directed bench for rrd_decode_pipe (2 channels, default widths).
module tb_rrd_decode_pipe;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned UOPC_W = 7;
    localparam int unsigned BRM_W  = 20;
    localparam int unsigned IMM_W  = 20;
    localparam int unsigned PL_W   = 64;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [NUM_CH-1:0]        io_iss_valid;
    logic                     io_iss_ready;
    logic [NUM_CH*UOPC_W-1:0] io_iss_uopc;
    logic [NUM_CH*5-1:0]      io_iss_mem_cmd;
    logic [NUM_CH*IMM_W-1:0]  io_iss_imm_packed;
    logic [NUM_CH*BRM_W-1:0]  io_iss_br_mask;
    logic [NUM_CH*PL_W-1:0]   io_iss_payload;
    logic [BRM_W-1:0]         io_brupdate_resolve_mask;
    logic [BRM_W-1:0]         io_brupdate_mispredict_mask;
    logic                     io_flush;
    logic [NUM_CH-1:0]        io_rrd_valid;
    logic                     io_rrd_ready;
    logic [NUM_CH*UOPC_W-1:0] io_rrd_uopc;
    logic [NUM_CH*4-1:0]      io_rrd_br_type;
    logic [NUM_CH*2-1:0]      io_rrd_op1_sel;
    logic [NUM_CH*3-1:0]      io_rrd_op2_sel;
    logic [NUM_CH*3-1:0]      io_rrd_imm_sel;
    logic [NUM_CH*4-1:0]      io_rrd_op_fcn;
    logic [NUM_CH-1:0]        io_rrd_fcn_dw;
    logic [NUM_CH*IMM_W-1:0]  io_rrd_imm_packed;
    logic [NUM_CH*BRM_W-1:0]  io_rrd_br_mask;
    logic [NUM_CH*PL_W-1:0]   io_rrd_payload;

    int checks   = 0;
    int failures = 0;

    rrd_decode_pipe #(
        .NUM_CH(NUM_CH), .UOPC_W(UOPC_W), .BRM_W(BRM_W), .IMM_W(IMM_W), .PL_W(PL_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io_iss_valid(io_iss_valid),
        .io_iss_ready(io_iss_ready),
        .io_iss_uopc(io_iss_uopc),
        .io_iss_mem_cmd(io_iss_mem_cmd),
        .io_iss_imm_packed(io_iss_imm_packed),
        .io_iss_br_mask(io_iss_br_mask),
        .io_iss_payload(io_iss_payload),
        .io_brupdate_resolve_mask(io_brupdate_resolve_mask),
        .io_brupdate_mispredict_mask(io_brupdate_mispredict_mask),
        .io_flush(io_flush),
        .io_rrd_valid(io_rrd_valid),
        .io_rrd_ready(io_rrd_ready),
        .io_rrd_uopc(io_rrd_uopc),
        .io_rrd_br_type(io_rrd_br_type),
        .io_rrd_op1_sel(io_rrd_op1_sel),
        .io_rrd_op2_sel(io_rrd_op2_sel),
        .io_rrd_imm_sel(io_rrd_imm_sel),
        .io_rrd_op_fcn(io_rrd_op_fcn),
        .io_rrd_fcn_dw(io_rrd_fcn_dw),
        .io_rrd_imm_packed(io_rrd_imm_packed),
        .io_rrd_br_mask(io_rrd_br_mask),
        .io_rrd_payload(io_rrd_payload)
    );

    always #5 clock = ~clock;

    // Branch table: opcode, br_type, op_fcn
    logic [6:0] bt_op  [6] = '{7'h18, 7'h19, 7'h1A, 7'h1B, 7'h1C, 7'h1D};
    logic [3:0] bt_typ [6] = '{4'd2, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6};
    logic [3:0] bt_fcn [6] = '{4'hE, 4'hA, 4'hC, 4'hE, 4'hC, 4'hE};

    // fcn_dw boundary table: opcode, expected fcn_dw
    logic [6:0] dw_op  [8] = '{7'h2A, 7'h2B, 7'h33, 7'h34, 7'h37, 7'h38, 7'h40, 7'h41};
    logic       dw_exp [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    task automatic set_idle();
        io_iss_valid                = '0;
        io_iss_uopc                 = '0;
        io_iss_mem_cmd              = '0;
        io_iss_imm_packed           = '0;
        io_iss_br_mask              = '0;
        io_iss_payload              = '0;
        io_brupdate_resolve_mask    = '0;
        io_brupdate_mispredict_mask = '0;
        io_flush                    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Return to an empty stage with ready asserted
    task automatic drain();
        set_idle();
        io_rrd_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        set_idle();
        io_rrd_ready = 1'b0;
        reset = 1'b1;
        #12;
        checks++;
        if (io_rrd_valid !== 2'b00) begin
            failures++; $display("FAIL reset_valid got=%b exp=00", io_rrd_valid);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (io_iss_ready !== 1'b1) begin
            failures++; $display("FAIL reset_iss_ready got=%b exp=1", io_iss_ready);
        end
        checks++;
        if (io_rrd_uopc !== '0 || io_rrd_imm_packed !== '0 || io_rrd_payload !== '0) begin
            failures++; $display("FAIL reset_regs uopc=%h imm=%h pl=%h exp=0", io_rrd_uopc, io_rrd_imm_packed, io_rrd_payload);
        end
    endtask

    task automatic test_first_issue();
        set_idle();
        io_rrd_ready               = 1'b1;
        io_iss_valid               = 2'b11;
        io_iss_uopc[6:0]           = 7'h19;
        io_iss_imm_packed[19:0]    = 20'h12345;
        io_iss_payload[63:0]       = 64'hDEAD_BEEF_0123_4567;
        io_iss_uopc[13:7]          = 7'h2B;
        tick();
        checks++;
        if (io_rrd_valid !== 2'b11) begin
            failures++; $display("FAIL first_valid got=%b exp=11", io_rrd_valid);
        end
        checks++;
        if (io_rrd_br_type[3:0] !== 4'd1 || io_rrd_op_fcn[3:0] !== 4'hA) begin
            failures++; $display("FAIL first_br got type=%0d fcn=%h exp 1/a", io_rrd_br_type[3:0], io_rrd_op_fcn[3:0]);
        end
        checks++;
        if (io_rrd_fcn_dw !== 2'b01) begin
            failures++; $display("FAIL first_fcn_dw got=%b exp=01", io_rrd_fcn_dw);
        end
        checks++;
        if (io_rrd_imm_packed[19:0] !== 20'h12345 || io_rrd_payload[63:0] !== 64'hDEAD_BEEF_0123_4567) begin
            failures++; $display("FAIL first_pass imm=%h pl=%h exp 12345/deadbeef01234567", io_rrd_imm_packed[19:0], io_rrd_payload[63:0]);
        end
    endtask

    task automatic test_back_to_back();
        set_idle();
        io_rrd_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            io_iss_valid     = 2'b01;
            io_iss_uopc[6:0] = bt_op[k];
            tick();
            checks++;
            if (io_rrd_valid[0] !== 1'b1 || io_rrd_br_type[3:0] !== bt_typ[k] ||
                io_rrd_op_fcn[3:0] !== bt_fcn[k] || io_rrd_fcn_dw[0] !== 1'b1) begin
                failures++;
                $display("FAIL b2b_branch op=%h got v=%b type=%0d fcn=%h dw=%b exp 1/%0d/%h/1",
                         bt_op[k], io_rrd_valid[0], io_rrd_br_type[3:0], io_rrd_op_fcn[3:0], io_rrd_fcn_dw[0], bt_typ[k], bt_fcn[k]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            io_iss_valid      = 2'b10;
            io_iss_uopc[13:7] = dw_op[k];
            tick();
            checks++;
            if (io_rrd_fcn_dw[1] !== dw_exp[k] || io_rrd_br_type[7:4] !== 4'd0 || io_rrd_valid !== 2'b10) begin
                failures++;
                $display("FAIL fcn_dw_edge op=%h got dw=%b type=%0d v=%b exp dw=%b type=0 v=10",
                         dw_op[k], io_rrd_fcn_dw[1], io_rrd_br_type[7:4], io_rrd_valid, dw_exp[k]);
            end
        end
        drain();
    endtask

    task automatic test_imm_zero();
        set_idle();
        io_rrd_ready             = 1'b1;
        io_iss_valid             = 2'b10;
        io_iss_uopc[13:7]        = 7'h01;
        io_iss_mem_cmd[9:5]      = 5'h6;
        io_iss_imm_packed[39:20] = 20'hABCDE;
        tick();
        checks++;
        if (io_rrd_imm_packed[39:20] !== 20'h0 || io_rrd_valid[1] !== 1'b1) begin
            failures++; $display("FAIL imm_ld_cmd6 got imm=%h v=%b exp 0/1", io_rrd_imm_packed[39:20], io_rrd_valid[1]);
        end
        io_iss_mem_cmd[9:5] = 5'h0;
        tick();
        checks++;
        if (io_rrd_imm_packed[39:20] !== 20'hABCDE) begin
            failures++; $display("FAIL imm_ld_cmd0 got=%h exp=abcde", io_rrd_imm_packed[39:20]);
        end
        io_iss_uopc[13:7] = 7'h43;
        tick();
        checks++;
        if (io_rrd_imm_packed[39:20] !== 20'h0) begin
            failures++; $display("FAIL imm_op43 got=%h exp=0", io_rrd_imm_packed[39:20]);
        end
        drain();
    endtask

    task automatic test_backpressure();
        set_idle();
        io_rrd_ready         = 1'b1;
        io_iss_valid         = 2'b01;
        io_iss_uopc[6:0]     = 7'h18;
        io_iss_payload[63:0] = 64'hAAAA;
        tick();
        io_rrd_ready         = 1'b0;
        io_iss_uopc[6:0]     = 7'h1A;
        io_iss_payload[63:0] = 64'hBBBB;
        #1;
        checks++;
        if (io_iss_ready !== 1'b0) begin
            failures++; $display("FAIL bp_ready_low got=%b exp=0", io_iss_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (io_iss_ready !== 1'b0 || io_rrd_valid[0] !== 1'b1 || io_rrd_uopc[6:0] !== 7'h18 ||
                io_rrd_payload[63:0] !== 64'hAAAA) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b uopc=%h pl=%h exp 0/1/18/aaaa",
                         c, io_iss_ready, io_rrd_valid[0], io_rrd_uopc[6:0], io_rrd_payload[63:0]);
            end
        end
        io_rrd_ready = 1'b1;
        tick();
        checks++;
        if (io_rrd_uopc[6:0] !== 7'h1A || io_rrd_br_type[3:0] !== 4'd3 || io_rrd_payload[63:0] !== 64'hBBBB) begin
            failures++; $display("FAIL bp_release got uopc=%h type=%0d pl=%h exp 1a/3/bbbb",
                                 io_rrd_uopc[6:0], io_rrd_br_type[3:0], io_rrd_payload[63:0]);
        end
        io_iss_valid = 2'b00;
        tick();
        checks++;
        if (io_rrd_valid !== 2'b00) begin
            failures++; $display("FAIL drain_clear got=%b exp=00", io_rrd_valid);
        end
        drain();
    endtask

    task automatic test_branch_update();
        set_idle();
        io_rrd_ready           = 1'b1;
        io_iss_valid           = 2'b01;
        io_iss_br_mask[19:0]   = 20'h00006;
        tick();
        io_rrd_ready             = 1'b0;
        io_iss_valid             = 2'b00;
        io_brupdate_resolve_mask = 20'h00002;
        tick();
        checks++;
        if (io_rrd_br_mask[19:0] !== 20'h00004 || io_rrd_valid[0] !== 1'b1) begin
            failures++; $display("FAIL resolve_held got mask=%h v=%b exp 00004/1", io_rrd_br_mask[19:0], io_rrd_valid[0]);
        end
        io_brupdate_resolve_mask    = '0;
        io_brupdate_mispredict_mask = 20'h00004;
        tick();
        checks++;
        if (io_rrd_valid !== 2'b00 || io_iss_ready !== 1'b1) begin
            failures++; $display("FAIL kill_held got v=%b rdy=%b exp 00/1", io_rrd_valid, io_iss_ready);
        end
        drain();
    endtask

    task automatic test_incoming_kill();
        set_idle();
        io_rrd_ready                = 1'b1;
        io_iss_valid                = 2'b11;
        io_iss_br_mask[19:0]        = 20'h00001;
        io_iss_br_mask[39:20]       = 20'h00002;
        io_brupdate_mispredict_mask = 20'h00001;
        tick();
        checks++;
        if (io_rrd_valid !== 2'b10) begin
            failures++; $display("FAIL kill_incoming got=%b exp=10", io_rrd_valid);
        end
        io_brupdate_mispredict_mask = '0;
        io_brupdate_resolve_mask    = 20'h00001;
        tick();
        checks++;
        if (io_rrd_valid !== 2'b11 || io_rrd_br_mask[19:0] !== 20'h0 || io_rrd_br_mask[39:20] !== 20'h00002) begin
            failures++; $display("FAIL resolve_incoming got v=%b m0=%h m1=%h exp 11/0/2",
                                 io_rrd_valid, io_rrd_br_mask[19:0], io_rrd_br_mask[39:20]);
        end
        drain();
    endtask

    task automatic test_flush();
        set_idle();
        io_rrd_ready = 1'b1;
        io_iss_valid = 2'b11;
        tick();
        io_flush = 1'b1;
        tick();
        checks++;
        if (io_rrd_valid !== 2'b00) begin
            failures++; $display("FAIL flush_load got=%b exp=00", io_rrd_valid);
        end
        io_flush = 1'b0;
        tick();
        io_rrd_ready = 1'b0;
        io_flush     = 1'b1;
        #1;
        checks++;
        if (io_iss_ready !== 1'b0) begin
            failures++; $display("FAIL flush_ready got=%b exp=0", io_iss_ready);
        end
        tick();
        checks++;
        if (io_rrd_valid !== 2'b00 || io_iss_ready !== 1'b1) begin
            failures++; $display("FAIL flush_stall got v=%b rdy=%b exp 00/1", io_rrd_valid, io_iss_ready);
        end
        io_flush     = 1'b0;
        io_rrd_ready = 1'b1;
        tick();
        io_rrd_ready = 1'b0;
        tick();
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (io_rrd_valid !== 2'b00) begin
            failures++; $display("FAIL reset_mid_stall got=%b exp=00", io_rrd_valid);
        end
        reset = 1'b0;
        drain();
    endtask

    initial begin
        reset        = 1'b0;
        io_rrd_ready = 1'b0;
        set_idle();
        test_reset();
        test_first_issue();
        drain();
        test_back_to_back();
        test_imm_zero();
        test_backpressure();
        test_branch_update();
        test_incoming_kill();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rrd_decode_pipe.md
Name: rrd_decode_pipe

Overview:
- Multi-channel register-read decode stage for the integer/memory issue path.
- Each issue channel's micro-op opcode is decoded into ALU/branch control fields, the packed immediate is conditioned, and the result is captured in one pipeline register per channel.
- Adds valid/ready backpressure, branch-kill/resolve tracking on the branch mask, and a full flush, none of which the purely combinational decode stage provides.
- Sits between the issue units and the register-file read / bypass stage.

Parameters:
- NUM_CH, 2, number of issue channels (1..4).
- UOPC_W, 7, micro-op opcode width.
- BRM_W, 20, branch mask width.
- IMM_W, 20, packed immediate width.
- PL_W, 64, opaque per-channel payload width (rob/ldq/stq idx, pdst, prs1/2, rtypes, etc.), passed through unmodified.

Ports:
- clock  in  1  stage clock
- reset  in  1  asynchronous, active-high reset
- io_iss_valid  in  NUM_CH  per-channel issue valid
- io_iss_ready  out  1  stage accepts issue this cycle; common to all channels
- io_iss_uopc  in  NUM_CH*UOPC_W  opcodes; channel i occupies bits [i*UOPC_W +: UOPC_W]; same packing for all vectors
- io_iss_mem_cmd  in  NUM_CH*5  memory command
- io_iss_imm_packed  in  NUM_CH*IMM_W  packed immediate
- io_iss_br_mask  in  NUM_CH*BRM_W  branch dependency mask
- io_iss_payload  in  NUM_CH*PL_W  pass-through payload
- io_brupdate_resolve_mask  in  BRM_W  branches resolved correctly this cycle
- io_brupdate_mispredict_mask  in  BRM_W  branches mispredicted this cycle
- io_flush  in  1  pipeline flush
- io_rrd_valid  out  NUM_CH  registered valid
- io_rrd_ready  in  1  downstream accepts
- io_rrd_uopc  out  NUM_CH*UOPC_W
- io_rrd_br_type  out  NUM_CH*4
- io_rrd_op1_sel  out  NUM_CH*2
- io_rrd_op2_sel  out  NUM_CH*3
- io_rrd_imm_sel  out  NUM_CH*3
- io_rrd_op_fcn  out  NUM_CH*4
- io_rrd_fcn_dw  out  NUM_CH
- io_rrd_imm_packed  out  NUM_CH*IMM_W
- io_rrd_br_mask  out  NUM_CH*BRM_W
- io_rrd_payload  out  NUM_CH*PL_W

Behaviour:

Reset:
- Asynchronous, active-high.
- All output registers are cleared to 0, including every io_rrd_valid bit.
- io_iss_ready = 1 immediately after reset deasserts.

Decode (combinational, per channel, on issue inputs):
- Uses the team's integer ALU decode table.
- Unlisted opcodes decode to all-zero fields with fcn_dw = 1.
- Branch decode, opcode -> br_type / op_fcn:
  - 0x18 -> 2 / 0xE
  - 0x19 -> 1 / 0xA
  - 0x1A -> 3 / 0xC
  - 0x1B -> 4 / 0xE
  - 0x1C -> 5 / 0xC
  - 0x1D -> 6 / 0xE
- fcn_dw = 0 for opcodes 0x2B–0x33 and 0x38–0x40.
- imm_packed is forced to 0 when opcode == 0x43, or when opcode == 0x01 and mem_cmd == 0x6; otherwise it passes through.

Handshake:
- io_iss_ready = ~(|io_rrd_valid) | io_rrd_ready. This is combinational; there is no skid buffer.
- Load enable ld = io_iss_ready. On ld, every channel's register captures its decoded fields, payload and updated mask.
- A channel's valid is loaded as io_iss_valid[i] & ~kill_in[i] & ~io_flush, where kill_in[i] = |(br_mask_in & io_brupdate_mispredict_mask).
- When ld = 0, registers hold their contents.
- A transfer out occurs when |io_rrd_valid & io_rrd_ready. With no new valid issue in that cycle, all valid bits clear on the edge.
- Latency is 1 cycle, issue to io_rrd. Throughput is one group per cycle while ready is held.

Branch update (applies every cycle, on the held entries and on the entries being loaded):
- The stored br_mask is br_mask & ~io_brupdate_resolve_mask.
- A held entry with |(br_mask & mispredict_mask) has its valid cleared on the edge, even while stalled. Its other fields are don't-care.
- Mispredict takes priority over resolve for the same bit.
- io_rrd_valid is purely registered. A mispredict takes effect at the next edge; downstream consumers filter the current cycle themselves.

Flush:
- io_flush clears all valids on the next edge and drops the incoming issue.
- io_flush has priority over load and over hold.
- io_iss_ready is unaffected by io_flush.

Simultaneous events:
- Stall plus mispredict: the entry is killed and io_iss_ready rises the following cycle.
- Transfer-out plus load in the same cycle: the new group replaces the old.
- Reset mid-stall: contents are lost and valids go to 0.

Test Plan:
1. Reset, then issue on ch0 with uopc 0x19, imm 0x12345, io_rrd_ready=1 -> next cycle io_rrd_valid[0]=1, br_type=1, op_fcn=0xA, fcn_dw=1, imm=0x12345.
2. ch1 issue uopc 0x01, mem_cmd 0x6, imm 0xABCDE -> io_rrd_imm_packed ch1 = 0, valid=1. Same with mem_cmd 0x0 -> imm 0xABCDE.
3. Backpressure: load a valid group, hold io_rrd_ready=0 for 3 cycles while presenting new issue -> io_iss_ready=0 and outputs stable. Raise ready -> new group appears on the next cycle.
4. Held ch0 br_mask 0x00006 while stalled:
   - resolve_mask 0x00002 -> br_mask becomes 0x00004, valid stays 1.
   - then mispredict_mask 0x00004 -> valid[0]=0 next cycle; io_iss_ready=1 in that cycle.
5. Incoming issue with br_mask 0x1 and mispredict 0x1 in the same cycle -> valid loads 0. With resolve 0x1 instead -> valid 1, br_mask 0.
6. io_flush with both channels valid and new issue pending -> all valids 0 next cycle. Assert reset mid-stall -> valids 0 asynchronously.
